// File: rtl/toggle_meter.sv
// Measures clk-cycle intervals between edges of q_in and queues them in a FWFT FIFO.
// Define TOGGLE_METER_MINMAX_EN to enable min/max interval tracking.
module toggle_meter #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     q_in,
  input  logic                     enable,
  input  logic                     clr_ovf,
  output logic [W-1:0]             period_data,
  output logic                     period_valid,
  input  logic                     period_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     sat,
  output logic [W-1:0]             min_period,
  output logic [W-1:0]             max_period
);

  // state     | meaning
  // S_IDLE    | not measuring, run_cnt held at 0
  // S_ARM     | waiting for the first edge to start timing
  // S_MEASURE | counting cycles, each edge pushes an interval
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [W-1:0]  ALL1     = '1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    r_state;
  logic          r_q_d;
  logic [W-1:0]  r_run_cnt;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_sat;

  logic          w_edge;
  logic          w_cnt_max;
  logic          w_push;
  logic [W-1:0]  w_push_val;
  logic          w_full;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;

  assign w_edge     = q_in ^ r_q_d;
  assign w_cnt_max  = (r_run_cnt == ALL1);
  assign w_push     = (r_state == S_MEASURE) && enable && w_edge;
  assign w_push_val = w_cnt_max ? ALL1 : r_run_cnt + W'(1);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = period_valid && period_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_write    = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    r_q_d <= q_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_run_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_run_cnt <= '0;
          if (enable) r_state <= S_ARM;
        end
        S_ARM: begin
          r_run_cnt <= '0;
          if (!enable)     r_state <= S_IDLE;
          else if (w_edge) r_state <= S_MEASURE;
        end
        S_MEASURE: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            r_run_cnt <= '0;
          end else if (w_edge) begin
            r_run_cnt <= '0;
          end else if (!w_cnt_max) begin
            r_run_cnt <= r_run_cnt + W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_run_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_push_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_write && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_write && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
      if (w_push && w_cnt_max) r_sat <= 1'b1;
      else if (clr_ovf)        r_sat <= 1'b0;
    end
  end

  assign period_valid = (r_count != '0);
  assign period_data  = period_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count   = r_count;
  assign overflow     = r_ovf;
  assign sat          = r_sat;

`ifdef TOGGLE_METER_MINMAX_EN
  logic [W-1:0] r_min;
  logic [W-1:0] r_max;
  logic         w_arming;

  assign w_arming = (r_state == S_IDLE) && enable;

  // Dropped samples still count towards the extremes.
  always_ff @(posedge clk) begin
    if (reset || w_arming) begin
      r_min <= ALL1;
      r_max <= '0;
    end else if (w_push) begin
      if (w_push_val < r_min) r_min <= w_push_val;
      if (w_push_val > r_max) r_max <= w_push_val;
    end
  end

  assign min_period = r_min;
  assign max_period = r_max;
`else
  assign min_period = '0;
  assign max_period = '0;
`endif

endmodule

// File: tb/tb_toggle_meter.sv
// Self-checking bench for toggle_meter: vector table, directed corner sequences and
// randomized traffic against an interval-level reference model.
module tb_toggle_meter;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int MAXV  = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset, q_in, enable, clr_ovf, period_ready;
  logic [W-1:0]  period_data, min_period, max_period;
  logic          period_valid, overflow, sat;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  toggle_meter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .enable(enable), .clr_ovf(clr_ovf),
    .period_data(period_data), .period_valid(period_valid), .period_ready(period_ready),
    .fifo_count(fifo_count), .overflow(overflow), .sat(sat),
    .min_period(min_period), .max_period(max_period)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tracks the cycle of the last edge and derives intervals by subtraction.
  bit   m_qd;
  int   m_mode;        // 0 idle, 1 armed-waiting, 2 measuring
  int   m_cyc;
  int   m_last;
  int   m_fifo[$];
  bit   m_ovf, m_sat;
  int   m_min, m_max;
  bit   cq;
  int   pops[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit q, input bit en, input bit clr, input bit rdy);
    bit edge_seen, pop, push, drop, sat_set;
    int val, raw;
    if (rst) begin
      m_qd = q; m_mode = 0; m_fifo.delete();
      m_ovf = 0; m_sat = 0; m_min = MAXV; m_max = 0;
    end else begin
      edge_seen = (q != m_qd);
      m_qd = q;
      pop = (m_fifo.size() > 0) && rdy;
      push = 0; sat_set = 0; val = 0;
      if (m_mode == 0) begin
        if (en) begin m_mode = 1; m_min = MAXV; m_max = 0; end
      end else if (!en) begin
        m_mode = 0;
      end else if (edge_seen) begin
        if (m_mode == 2) begin
          raw = m_cyc - m_last;
          val = (raw > MAXV) ? MAXV : raw;
          sat_set = (raw > MAXV);
          push = 1;
        end
        m_mode = 2;
        m_last = m_cyc;
      end
      drop = push && (m_fifo.size() == DEPTH) && !pop;
      if (pop) void'(m_fifo.pop_front());
      if (push && !drop) m_fifo.push_back(val);
      if (push) begin
        if (val < m_min) m_min = val;
        if (val > m_max) m_max = val;
      end
      if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
      if (sat_set) m_sat = 1; else if (clr) m_sat = 0;
    end
    m_cyc++;
  endtask

  task automatic step(input bit rst, input bit q, input bit en, input bit clr, input bit rdy);
    reset = rst; q_in = q; enable = en; clr_ovf = clr; period_ready = rdy;
    if (rdy && period_valid && !rst) pops.push_back(int'(period_data));
    @(posedge clk);
    model_step(rst, q, en, clr, rdy);
    #1;
    chk("valid", int'(period_valid), int'(m_fifo.size() > 0));
    chk("data", int'(period_data), (m_fifo.size() > 0) ? m_fifo[0] : 0);
    chk("count", int'(fifo_count), m_fifo.size());
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("sat", int'(sat), int'(m_sat));
`ifdef TOGGLE_METER_MINMAX_EN
    chk("min", int'(min_period), m_min);
    chk("max", int'(max_period), m_max);
`else
    chk("min", int'(min_period), 0);
    chk("max", int'(max_period), 0);
`endif
  endtask

  // Each edge lands 'period' cycles after the previous one.
  task automatic toggle_edges(input int period, input int edges, input bit rdy);
    for (int e = 0; e < edges; e++) begin
      repeat (period - 1) step(0, cq, 1, 0, rdy);
      cq = ~cq;
      step(0, cq, 1, 0, rdy);
    end
  endtask

  task automatic do_reset();
    step(1, cq, 0, 0, 0);
    pops.delete();
  endtask

  task automatic chk_pops(input string nm, input int n, input int v);
    chk({nm, "_npops"}, pops.size(), n);
    foreach (pops[i]) chk({nm, "_popval"}, pops[i], v);
    pops.delete();
  endtask

  typedef struct {
    bit rst, q, en, clr, rdy;
    int ev, ed, ec, eo;
  } vec_t;
  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1,0,0,0,0, 0,0,0,0};
    tbl[1]  = '{0,0,1,0,0, 0,0,0,0};
    tbl[2]  = '{0,1,1,0,0, 0,0,0,0};
    tbl[3]  = '{0,1,1,0,0, 0,0,0,0};
    tbl[4]  = '{0,0,1,0,0, 1,2,1,0};
    tbl[5]  = '{0,0,1,0,0, 1,2,1,0};
    tbl[6]  = '{0,1,1,0,0, 1,2,2,0};
    tbl[7]  = '{0,1,1,0,0, 1,2,2,0};
    tbl[8]  = '{0,0,1,0,0, 1,2,3,0};
    tbl[9]  = '{0,0,1,0,0, 1,2,3,0};
    tbl[10] = '{0,1,1,0,0, 1,2,4,0};
    tbl[11] = '{0,1,1,0,0, 1,2,4,0};
    tbl[12] = '{0,0,1,0,0, 1,2,4,1};
    tbl[13] = '{0,0,1,0,1, 1,2,3,1};
    tbl[14] = '{0,0,1,1,0, 1,2,3,0};
    tbl[15] = '{0,1,1,0,0, 1,2,4,0};
    tbl[16] = '{0,1,0,0,1, 1,2,3,0};

    m_cyc = 0; m_last = 0; m_mode = 0; m_qd = 0;
    m_ovf = 0; m_sat = 0; m_min = MAXV; m_max = 0;
    reset = 1; q_in = 0; enable = 0; clr_ovf = 0; period_ready = 0; cq = 0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].q, tbl[i].en, tbl[i].clr, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), int'(period_valid), tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), tbl[i].ev ? int'(period_data) : 0, tbl[i].ed);
      chk($sformatf("tbl%0d_count", i), int'(fifo_count), tbl[i].ec);
      chk($sformatf("tbl%0d_ovf", i), int'(overflow), tbl[i].eo);
    end
    cq = 1;

    // Period 4, five edges, consumer always ready.
    do_reset();
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_data", int'(period_data), 0);
    toggle_edges(4, 5, 1);
    repeat (2) step(0, cq, 1, 0, 1);
    chk_pops("t1", 4, 4);
    chk("t1_ovf", int'(overflow), 0);

    // Overfill, drain in order, clear overflow.
    do_reset();
    toggle_edges(6, 7, 0);
    chk("t2_count", int'(fifo_count), 4);
    chk("t2_ovf", int'(overflow), 1);
    repeat (4) step(0, cq, 1, 0, 1);
    chk_pops("t2", 4, 6);
    step(0, cq, 1, 1, 0);
    chk("t2_clr", int'(overflow), 0);

    // Saturation then a normal interval.
    do_reset();
    toggle_edges(2, 1, 0);
    repeat (300) step(0, cq, 1, 0, 0);
    cq = ~cq;
    step(0, cq, 1, 0, 0);
    chk("t3_data", int'(period_data), 255);
    chk("t3_sat", int'(sat), 1);
    toggle_edges(10, 1, 0);
    chk("t3_count", int'(fifo_count), 2);
    step(0, cq, 1, 0, 1);
    chk("t3_second", int'(period_data), 10);

    // Disable mid-interval discards the partial interval.
    do_reset();
    toggle_edges(5, 2, 1);
    repeat (2) step(0, cq, 1, 0, 1);
    repeat (3) step(0, cq, 0, 0, 1);
    toggle_edges(5, 4, 1);
    repeat (2) step(0, cq, 1, 0, 1);
    chk_pops("t4", 4, 5);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    toggle_edges(3, 5, 0);
    chk("t5_full", int'(fifo_count), 4);
    repeat (2) step(0, cq, 1, 0, 0);
    cq = ~cq;
    step(0, cq, 1, 0, 1);
    chk("t5_pp_count", int'(fifo_count), 4);
    chk("t5_pp_ovf", int'(overflow), 0);

    // Reset with three entries and a sticky overflow pending.
    do_reset();
    toggle_edges(3, 6, 0);
    step(0, cq, 1, 0, 1);
    chk("t5_three", int'(fifo_count), 3);
    step(1, cq, 1, 0, 0);
    chk("t5_rst_valid", int'(period_valid), 0);
    chk("t5_rst_count", int'(fifo_count), 0);
    chk("t5_rst_ovf", int'(overflow), 0);

    // Min/max tracking of intervals 7, 3, 9.
    do_reset();
    toggle_edges(4, 1, 1);
    toggle_edges(7, 1, 1);
    toggle_edges(3, 1, 1);
    toggle_edges(9, 1, 1);
`ifdef TOGGLE_METER_MINMAX_EN
    chk("t6_min", int'(min_period), 3);
    chk("t6_max", int'(max_period), 9);
`else
    chk("t6_min_off", int'(min_period), 0);
    chk("t6_max_off", int'(max_period), 0);
`endif
    step(0, cq, 0, 0, 1);
    step(0, cq, 1, 0, 1);
`ifdef TOGGLE_METER_MINMAX_EN
    chk("t6_min_rearm", int'(min_period), 255);
    chk("t6_max_rearm", int'(max_period), 0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) cq = ~cq;
      step($urandom_range(499) == 0, cq, $urandom_range(31) != 0,
           $urandom_range(19) == 0, $urandom_range(1) == 1);
    end
    pops.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
